aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Iterative AES key schedule (FIPS-197 KeyExpansion): one 32-bit word per clock.
//  Latches a cipher key on start, generates all 4*(Nr+1) words and holds round keys k_sch[0:Nr].
//  Sits directly upstream of aes_cipher and drives its k_sch input.
//  valid gates cipher loading.
// PARAMETERS
//  Nk     4              key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256)
//  Nr     Nk+6           number of rounds; k_sch has Nr+1 entries
//  NW     4*(Nr+1)       total schedule words (localparam)
// PORTS
//  clk    in   1         single clock, all state rising-edge
//  rst    in   1         synchronous, active-high reset
//  start  in   1         request expansion of key; accepted only when busy==0
//  key    in   Nk*32     cipher key; sampled only on the accepted start cycle
//  busy   out  1         expansion in progress
//  valid  out  1         level: k_sch complete and stable
//  k_sch  out  [127:0] [0:Nr]  round keys, registered, unpacked array
// BEHAVIOUR
//  Byte order (little-endian, same as cipher datapath):
//   - FIPS byte 0 at key[7:0]; word w[i] at key[32i+31:32i].
//   - k_sch[r][32c+31:32c] = w[4r+c].
//   - Rcon XORs into bits [7:0]; RotWord({b3,b2,b1,b0}) = {b0,b3,b2,b1}.
//  Reset: busy=0, valid=0, every k_sch entry=0, word index=0, rcon=8'h01.
//  Accepted start (start & !busy) at edge E0:
//   - w[0..Nk-1] loaded from key; Nk-word sliding window loaded.
//   - busy=1, valid=0, i=Nk, rcon=8'h01.
//  Edges E1..E(NW-Nk): one word per edge, w[i] = w[i-Nk] ^ t, then i++.
//   - i%Nk==0: t = SubWord(RotWord(w[i-1])) ^ {24'h0,rcon}; after use rcon = xtime(rcon) (mod 8'h1b).
//   - Nk==8 && i%Nk==4: t = SubWord(w[i-1]).
//   - otherwise: t = w[i-1].
//  Edge writing w[NW-1]: busy->0, valid->1 together.
//   - Latency start->valid: 40 / 46 / 52 cycles for Nk=4/6/8.
//  start while busy: ignored; no restart, no key resample.
//  start while valid & !busy: accepted; valid drops at E0.
//   - Old k_sch entries stay visible until overwritten.
//   - Consumers must wait for valid.
//  start and rst in the same cycle: rst wins.
//  rst mid-expansion: full reset next edge; partial schedule discarded (entries=0).
//  rcon register is 8 bits. Nk=4 needs at most 10 updates (8'h36); no wrap handling needed.
// STRUCTURE
//  aes_pkg (shared with aes_cipher):
//   - SBOX constant table.
//   - SubWord, RotWord, xtime functions.
//   - typedef word_t = logic [31:0]; typedef block_t = logic [127:0].
//  Sub-module aes_sub_word: 4 parallel SBOX lookups (combinational); single instance here.
//  Local state:
//   - Nk-deep word window shift register; word counter sized $clog2(NW+1).
//   - rcon register; busy/valid flags.
//   - k_sch storage: write w[i] into entry i/4, lane i%4.
// TESTING
//  1 Nk=4, key=128'h3c4fcf098815f7aba6d2ae2816157e2b (FIPS A.1), start 1 cycle:
//    -> valid exactly 40 cycles later;
//       k_sch[1]=128'h05766c2a3939a323b12c548817fefaa0;
//       k_sch[10]=128'ha60c63b6c80c3fe18925eec9a8f914d0.
//  2 Nk=8, key bytes 00..1f ascending (FIPS C.3):
//    -> valid after 52 cycles; k_sch[14] matches C.3 final round key (byte-reversed).
//  3 Nk=6, FIPS A.2 key -> valid after 46 cycles; all 13 entries match A.2 table.
//  4 start pulsed again at cycle 10 of an expansion:
//    -> ignored; result and latency identical to scenario 1.
//  5 rst at cycle 20 of expansion:
//    -> next cycle busy=0, valid=0, all k_sch=0; new start completes normally.
//  6 Chain with aes_cipher:
//    -> pt=FIPS C.1 plaintext, load once valid=1;
//       ct = 128'h5ac5b47080b7cdd830047b6ad8e0c469 (69c4e0d8...5ac5 byte-reversed).

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box table and byte/word helper functions
// Contents:
//   word_t, block_t  32-bit schedule word, 128-bit round key / state block
//   SBOX             forward S-box, indexed by input byte
//   xtime            multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   rot_word         little-endian RotWord: {b3,b2,b1,b0} -> {b0,b3,b2,b1}
//   sub_word         S-box applied to each byte of a word
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 lives in bits [7:0], so rotating bytes "left" in FIPS terms
    // is a right shift by one byte here.
    function automatic word_t rot_word(input word_t w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        word_t y;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            y[8*k +: 8] = SBOX[w[8*k +: 8]];
        end
        return y;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - request/schedule bundle between key source, expander and cipher
// Signals:
//   start  request expansion of key (master -> slave)
//   key    Nk*32-bit cipher key, little-endian words (master -> slave)
//   busy   expansion in progress (slave -> master)
//   valid  k_sch complete and stable (slave -> master)
//   k_sch  round keys 0..Nr (slave -> master)
interface aes_key_expand_if #(
    parameter int Nk = 4
);
    import aes_pkg::*;

    localparam int Nr = Nk + 6;

    logic              start;
    logic [Nk*32-1:0]  key;
    logic              busy;
    logic              valid;
    block_t            k_sch [0:Nr];

    modport master (
        output start,
        output key,
        input  busy,
        input  valid,
        input  k_sch
    );

    modport slave (
        input  start,
        input  key,
        output busy,
        output valid,
        output k_sch
    );

endinterface

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - four parallel S-box lookups on one 32-bit word
// Ports:
//   a  in   word_t  input word
//   y  out  word_t  S-box of each byte of a, same byte positions
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t a,
    output word_t y
);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign y[8*k +: 8] = SBOX[a[8*k +: 8]];
    end

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES key schedule producing one word per clock
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of aes_key_expand_if (start/key in, busy/valid/k_sch out)
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic            clk,
    input  logic            rst,
    aes_key_expand_if.slave bus
);

    localparam int Nr = Nk + 6;
    localparam int NW = 4 * (Nr + 1);
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          start_ok;

    logic [CW-1:0] cnt;     // index i of the word being generated
    logic [2:0]    ph;      // i % Nk, tracked incrementally to avoid a divider
    logic [7:0]    rcon;
    word_t         win [0:Nk-1];   // win[0] = w[i-Nk] ... win[Nk-1] = w[i-1]
    word_t         wrd [0:NW-1];   // full schedule storage, one word per entry

    word_t         prev;
    word_t         sub_in;
    word_t         sub_out;
    word_t         t;
    word_t         new_w;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    start_ok   = 1'b1;
                    state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (cnt == CW'(NW - 1)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word generator: a single S-box instance serves both the RotWord
    // path (ph==0) and the AES-256 mid-key SubWord path (ph==4).
    // ------------------------------------------------------------------
    assign prev   = win[Nk-1];
    assign sub_in = (ph == 3'd0) ? rot_word(prev) : prev;

    aes_sub_word u_sub_word (
        .a (sub_in),
        .y (sub_out)
    );

    always_comb begin
        t = prev;
        if (ph == 3'd0) begin
            t = sub_out ^ {24'h0, rcon};
        end else if ((Nk == 8) && (ph == 3'd4)) begin
            t = sub_out;
        end
    end

    assign new_w = win[0] ^ t;

    // ------------------------------------------------------------------
    // Datapath state. On a restart only w[0..Nk-1] are rewritten; later
    // entries keep the previous schedule until regenerated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            ph   <= '0;
            rcon <= 8'h01;
            for (int j = 0; j < Nk; j++) begin
                win[j] <= '0;
            end
            for (int j = 0; j < NW; j++) begin
                wrd[j] <= '0;
            end
        end else if (start_ok) begin
            cnt  <= CW'(Nk);
            ph   <= '0;
            rcon <= 8'h01;
            for (int j = 0; j < Nk; j++) begin
                win[j] <= bus.key[32*j +: 32];
                wrd[j] <= bus.key[32*j +: 32];
            end
        end else if (state == ST_EXPAND) begin
            cnt <= cnt + CW'(1);
            ph  <= (ph == 3'(Nk - 1)) ? 3'd0 : ph + 3'd1;
            if (ph == 3'd0) begin
                rcon <= xtime(rcon);
            end
            for (int j = 0; j < Nk - 1; j++) begin
                win[j] <= win[j+1];
            end
            win[Nk-1] <= new_w;
            for (int j = 0; j < NW; j++) begin
                if (cnt == CW'(j)) begin
                    wrd[j] <= new_w;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy  = (state == ST_EXPAND);
    assign bus.valid = (state == ST_DONE);

    always_comb begin
        for (int r = 0; r <= Nr; r++) begin
            bus.k_sch[r] = {wrd[4*r+3], wrd[4*r+2], wrd[4*r+1], wrd[4*r]};
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - self-checking bench for aes_key_expand (Nk=4/6/8)
module tb_aes_key_expand;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_expand_if #(.Nk(4)) bus4 ();
    aes_key_expand_if #(.Nk(6)) bus6 ();
    aes_key_expand_if #(.Nk(8)) bus8 ();

    aes_key_expand #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    aes_key_expand #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));
    aes_key_expand #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           nk;
        logic [255:0] key;
        int           lat;
        int           ridx;     // -1: no fixed round-key check
        logic [127:0] rkey;
        bit           has_ct;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [0:5];
    logic [127:0] cur_rk [0:14];
    logic [31:0]  rw [0:59];

    localparam logic [255:0] KEY_A1 = 256'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [255:0] KEY_A2 = 256'h7b6b2c52d2eaf862e57990802bf310c852640edaf7b0738e;
    localparam logic [255:0] KEY_C1 = 256'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] KEY_C2 = 256'h161514131211100f0e0d0c0b0a09080706050403020100 | (256'h17 << 184);
    localparam logic [255:0] KEY_C3 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT_C   = 128'hffeeddccbbaa99887766554433221100;

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int nk, input logic s, input logic [255:0] k);
        bus4.start = 1'b0;
        bus6.start = 1'b0;
        bus8.start = 1'b0;
        case (nk)
            4: begin bus4.start = s; bus4.key = k[127:0]; end
            6: begin bus6.start = s; bus6.key = k[191:0]; end
            default: begin bus8.start = s; bus8.key = k; end
        endcase
    endtask

    function automatic logic get_busy(input int nk);
        case (nk)
            4: return bus4.busy;
            6: return bus6.busy;
            default: return bus8.busy;
        endcase
    endfunction

    function automatic logic get_valid(input int nk);
        case (nk)
            4: return bus4.valid;
            6: return bus6.valid;
            default: return bus8.valid;
        endcase
    endfunction

    task automatic grab(input int nk);
        for (int r = 0; r < 15; r++) cur_rk[r] = '0;
        case (nk)
            4: for (int r = 0; r <= 10; r++) cur_rk[r] = bus4.k_sch[r];
            6: for (int r = 0; r <= 12; r++) cur_rk[r] = bus6.k_sch[r];
            default: for (int r = 0; r <= 14; r++) cur_rk[r] = bus8.k_sch[r];
        endcase
    endtask

    function automatic int count_nonzero(input int nk);
        int n = 0;
        for (int r = 0; r <= nk + 6; r++) if (cur_rk[r] !== '0) n++;
        return n;
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        case (n)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b;  10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Straight FIPS KeyExpansion in little-endian word form, Rcon from a table.
    function automatic void ref_expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                rw[i] = key[32*i +: 32];
            end else begin
                t = rw[i-1];
                if (i % nk == 0) t = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rcon_of(i / nk)};
                else if (nk == 8 && i % nk == 4) t = sub_word(t);
                rw[i] = rw[i-nk] ^ t;
            end
        end
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference cipher using the round keys captured from the DUT.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   u [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] b;
        b = pt ^ cur_rk[0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4*c+r] = SBOX[b[8*(4*((c+r)%4)+r) +: 8]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (rd != nr) begin
                    b[8*(4*c)   +: 8] = gm2(a0) ^ gm2(a1) ^ a1 ^ a2 ^ a3;
                    b[8*(4*c+1) +: 8] = a0 ^ gm2(a1) ^ gm2(a2) ^ a2 ^ a3;
                    b[8*(4*c+2) +: 8] = a0 ^ a1 ^ gm2(a2) ^ gm2(a3) ^ a3;
                    b[8*(4*c+3) +: 8] = gm2(a0) ^ a0 ^ a1 ^ a2 ^ gm2(a3);
                end else begin
                    b[8*(4*c)   +: 8] = a0;
                    b[8*(4*c+1) +: 8] = a1;
                    b[8*(4*c+2) +: 8] = a2;
                    b[8*(4*c+3) +: 8] = a3;
                end
            end
            b = b ^ cur_rk[rd];
        end
        return b;
    endfunction

    // Start an expansion and count edges from E0 until valid.
    task automatic run_expand(input int nk, input logic [255:0] key, input int repulse_at,
                              input string tag, output int lat);
        @(negedge clk);
        drive(nk, 1'b1, key);
        @(negedge clk);
        drive(nk, 1'b0, ~key);
        lat = 0;
        check_val({tag, "_valid_after_start"}, 128'(get_valid(nk)), 128'd0);
        check_val({tag, "_busy_after_start"}, 128'(get_busy(nk)), 128'd1);
        while (!get_valid(nk) && lat < 200) begin
            drive(nk, (lat == repulse_at), ~key);
            @(negedge clk);
            lat++;
        end
        drive(nk, 1'b0, ~key);
        check_val({tag, "_busy_at_valid"}, 128'(get_busy(nk)), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int    lat;
        int    bad;
        string tag;

        // Reset with start held high: reset must win.
        rst = 1'b1;
        bus4.key = '0; bus6.key = '0; bus8.key = '0;
        bus4.start = 1'b1; bus6.start = 1'b1; bus8.start = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 4; n <= 8; n += 2) begin
            tag = $sformatf("reset_nk%0d", n);
            check_val({tag, "_busy"}, 128'(get_busy(n)), 128'd0);
            check_val({tag, "_valid"}, 128'(get_valid(n)), 128'd0);
            grab(n);
            check_val({tag, "_ksch_nonzero"}, 128'(count_nonzero(n)), 128'd0);
        end
        drive(4, 1'b0, '0);
        rst = 1'b0;

        vecs[0] = '{4, KEY_A1, 40, 1,  128'h05766c2a3939a323b12c548817fefaa0, 1'b1,
                    128'h340737e0a29831318d305a88a8f64332, 128'h320b6a19978511dcfb09dc021d842539};
        vecs[1] = '{4, KEY_A1, 40, 10, 128'ha60c63b6c80c3fe18925eec9a8f914d0, 1'b0, '0, '0};
        vecs[2] = '{4, KEY_C1, 40, 0,  KEY_C1[127:0], 1'b1, PT_C, 128'h5ac5b47080b7cdd830047b6ad8e0c469};
        vecs[3] = '{6, KEY_A2, 46, 0,  128'he57990802bf310c852640edaf7b0738e, 1'b0, '0, '0};
        vecs[4] = '{6, KEY_C2, 46, -1, '0, 1'b1, PT_C, 128'h91710deca070af6ee0df4c86a47ca9dd};
        vecs[5] = '{8, KEY_C3, 52, 14, 128'h36de686d3cc21a37e97909bfcc79fc24, 1'b1,
                    PT_C, 128'h8960494b9049fcebf456751cab7a28e ^ 128'h0};

        vecs[5].ct = 128'h8960494b9049fceabf456751cab7a28e;

        for (int v = 0; v < 6; v++) begin
            tag = $sformatf("v%0d", v);
            run_expand(vecs[v].nk, vecs[v].key, -1, tag, lat);
            check_val({tag, "_latency"}, 128'(lat), 128'(vecs[v].lat));
            grab(vecs[v].nk);
            ref_expand(vecs[v].nk, vecs[v].key);
            bad = 0;
            for (int r = 0; r <= vecs[v].nk + 6; r++)
                if (cur_rk[r] !== {rw[4*r+3], rw[4*r+2], rw[4*r+1], rw[4*r]}) bad++;
            check_val({tag, "_entries_wrong"}, 128'(bad), 128'd0);
            if (vecs[v].ridx >= 0)
                check_val($sformatf("%s_ksch%0d", tag, vecs[v].ridx), cur_rk[vecs[v].ridx], vecs[v].rkey);
            if (vecs[v].has_ct)
                check_val({tag, "_ct"}, encrypt(vecs[v].pt, vecs[v].nk + 6), vecs[v].ct);
        end

        // Second start during expansion is ignored.
        run_expand(4, KEY_A1, 10, "repulse", lat);
        check_val("repulse_latency", 128'(lat), 128'd40);
        grab(4);
        check_val("repulse_ksch10", cur_rk[10], 128'ha60c63b6c80c3fe18925eec9a8f914d0);
        check_val("repulse_ksch0", cur_rk[0], KEY_A1[127:0]);

        // Reset in the middle of an expansion.
        @(negedge clk);
        drive(4, 1'b1, KEY_C1);
        @(negedge clk);
        drive(4, 1'b0, '0);
        repeat (19) @(negedge clk);
        check_val("midrst_busy_before", 128'(get_busy(4)), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", 128'(get_busy(4)), 128'd0);
        check_val("midrst_valid", 128'(get_valid(4)), 128'd0);
        grab(4);
        check_val("midrst_ksch_nonzero", 128'(count_nonzero(4)), 128'd0);
        run_expand(4, KEY_A1, -1, "postrst", lat);
        check_val("postrst_latency", 128'(lat), 128'd40);
        grab(4);
        check_val("postrst_ksch1", cur_rk[1], 128'h05766c2a3939a323b12c548817fefaa0);
        check_val("postrst_ksch10", cur_rk[10], 128'ha60c63b6c80c3fe18925eec9a8f914d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
